// File: rtl/iomem_timer_if.sv
// ============================================================================
// Module   : iomem_timer_if
// Summary  : PicoSoC iomem request/response bundle with CPU and responder views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface iomem_timer_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_ready,
      input  iomem_rdata
   );

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_ready,
      output iomem_rdata
   );
endinterface

`default_nettype wire

// File: rtl/iomem_timer.sv
// ============================================================================
// Module   : iomem_timer
// Summary  : iomem-bus 32-bit down-counting timer with prescaler, one-shot or
//            auto-reload modes and a level interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iomem_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  wire logic    clk,
   input  wire logic    reset,
   iomem_timer_if.slave bus,
   output logic         irq
);

   localparam logic [15:0] c_presc_max = 16'(PRESCALE - 1);
   localparam logic [1:0]  c_off_ctrl   = 2'd0;
   localparam logic [1:0]  c_off_load   = 2'd1;
   localparam logic [1:0]  c_off_count  = 2'd2;
   localparam logic [1:0]  c_off_status = 2'd3;

   function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

   logic        r_ready;
   logic [31:0] r_rdata;
   logic        r_enable;
   logic        r_auto_reload;
   logic        r_irq_en;
   logic [31:0] r_load;
   logic [31:0] r_count;
   logic        r_expired;
   logic [15:0] r_presc;

   logic        w_sel;
   logic        w_acc;
   logic        w_wr;
   logic [1:0]  w_off;
   logic        w_wr_ctrl;
   logic        w_wr_load;
   logic        w_wr_count;
   logic        w_status_clr;
   logic [2:0]  w_ctrl_new;
   logic        w_tick;
   logic        w_expire;
   logic [31:0] w_rd_mux;
   logic        w_unused;

   assign w_unused = ^bus.iomem_addr[1:0];

   // Accept only on the first cycle of a request; the cycle after ready is a bus turnaround.
   assign w_sel        = bus.iomem_valid && (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
   assign w_acc        = w_sel && !r_ready;
   assign w_wr         = w_acc && (bus.iomem_wstrb != 4'b0000);
   assign w_off        = bus.iomem_addr[3:2];
   assign w_wr_ctrl    = w_wr && (w_off == c_off_ctrl);
   assign w_wr_load    = w_wr && (w_off == c_off_load);
   assign w_wr_count   = w_wr && (w_off == c_off_count);
   assign w_status_clr = w_wr && (w_off == c_off_status) && bus.iomem_wstrb[0] && bus.iomem_wdata[0];
   assign w_ctrl_new   = bus.iomem_wstrb[0] ? bus.iomem_wdata[2:0]
                                            : {r_irq_en, r_auto_reload, r_enable};

   assign w_tick   = r_enable && (r_presc == c_presc_max);
   assign w_expire = w_tick && (r_count == 32'd0);

   always_comb begin
      w_rd_mux = 32'd0;
      case (w_off)
         c_off_ctrl:   w_rd_mux = {29'd0, r_irq_en, r_auto_reload, r_enable};
         c_off_load:   w_rd_mux = r_load;
         c_off_count:  w_rd_mux = r_count;
         c_off_status: w_rd_mux = {31'd0, r_expired};
         default:      w_rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ready       <= 1'b0;
         r_rdata       <= 32'd0;
         r_enable      <= 1'b0;
         r_auto_reload <= 1'b0;
         r_irq_en      <= 1'b0;
         r_load        <= 32'd0;
         r_count       <= 32'd0;
         r_expired     <= 1'b0;
         r_presc       <= 16'd0;
      end else begin
         r_ready <= w_acc;
         r_rdata <= w_acc ? w_rd_mux : 32'd0;

         if (!r_enable || (w_wr_ctrl && w_ctrl_new[0])) begin
            r_presc <= 16'd0;
         end else if (w_tick) begin
            r_presc <= 16'd0;
         end else begin
            r_presc <= r_presc + 16'd1;
         end

         // A CTRL write in the expiry cycle takes precedence over the one-shot stop.
         if (w_wr_ctrl) begin
            {r_irq_en, r_auto_reload, r_enable} <= w_ctrl_new;
         end else if (w_expire && !r_auto_reload) begin
            r_enable <= 1'b0;
         end

         if (w_wr_load) begin
            r_load <= f_merge(r_load, bus.iomem_wdata, bus.iomem_wstrb);
         end

         if (w_wr_count) begin
            r_count <= f_merge(r_count, bus.iomem_wdata, bus.iomem_wstrb);
         end else if (w_tick) begin
            if (r_count != 32'd0) begin
               r_count <= r_count - 32'd1;
            end else if (r_auto_reload) begin
               r_count <= r_load;
            end
         end

         if (w_expire) begin
            r_expired <= 1'b1;
         end else if (w_status_clr) begin
            r_expired <= 1'b0;
         end
      end
   end

   assign bus.iomem_ready = r_ready;
   assign bus.iomem_rdata = r_rdata;
   assign irq             = r_expired && r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_iomem_timer.sv
// ============================================================================
// Module   : tb_iomem_timer
// Summary  : Directed bench for iomem_timer: two instances sharing one bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iomem_timer;

   localparam logic [31:0] c_B1 = 32'h0300_0000;
   localparam logic [31:0] c_B4 = 32'h0300_0100;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        exp_rdy;
      logic        chk_data;
      logic [31:0] exp_data;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic irq1;
   logic irq4;
   int   checks = 0;
   int   errors = 0;

   iomem_timer_if bus1();
   iomem_timer_if bus4();

   assign bus4.iomem_valid = bus1.iomem_valid;
   assign bus4.iomem_wstrb = bus1.iomem_wstrb;
   assign bus4.iomem_addr  = bus1.iomem_addr;
   assign bus4.iomem_wdata = bus1.iomem_wdata;

   logic        ready_any;
   logic [31:0] rdata_any;
   assign ready_any = bus1.iomem_ready | bus4.iomem_ready;
   assign rdata_any = bus1.iomem_rdata | bus4.iomem_rdata;

   iomem_timer #(.BASE_ADDR(c_B1), .PRESCALE(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave),
      .irq   (irq1)
   );

   iomem_timer #(.BASE_ADDR(c_B4), .PRESCALE(4)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave),
      .irq   (irq4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one request, samples the response one edge later, then confirms a single ready pulse.
   task automatic access(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                         output logic rdy, output logic [31:0] rd);
      bus1.iomem_valid = 1'b1;
      bus1.iomem_addr  = addr;
      bus1.iomem_wstrb = wstrb;
      bus1.iomem_wdata = wdata;
      step();
      rdy = ready_any;
      rd  = rdata_any;
      bus1.iomem_valid = 1'b0;
      bus1.iomem_wstrb = 4'b0000;
      step();
      chk("ready_single_pulse", {31'd0, ready_any}, 32'd0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                     input string name);
      logic        rdy;
      logic [31:0] rd;
      access(addr, wstrb, wdata, rdy, rd);
      chk({name, "_ready"}, {31'd0, rdy}, 32'd1);
   endtask

   task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string name);
      logic        rdy;
      logic [31:0] rd;
      access(addr, 4'b0000, 32'd0, rdy, rd);
      chk({name, "_ready"}, {31'd0, rdy}, 32'd1);
      chk(name, rd, exp);
   endtask

   vec_t vecs[23];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{c_B1 + 32'h0,  4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[1]  = '{c_B1 + 32'h4,  4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[2]  = '{c_B1 + 32'h8,  4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[3]  = '{c_B1 + 32'hC,  4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[4]  = '{c_B4 + 32'h0,  4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[5]  = '{c_B1 + 32'h4,  4'h3, 32'hDEADBEEF,  1'b1, 1'b0, 32'h0};
      vecs[6]  = '{c_B1 + 32'h4,  4'h0, 32'h0,         1'b1, 1'b1, 32'h0000BEEF};
      vecs[7]  = '{c_B1 + 32'h10, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0};
      vecs[8]  = '{c_B1 + 32'h4,  4'hC, 32'h12345678,  1'b1, 1'b0, 32'h0};
      vecs[9]  = '{c_B1 + 32'h7,  4'h0, 32'h0,         1'b1, 1'b1, 32'h1234BEEF};
      vecs[10] = '{c_B1 + 32'h0,  4'hF, 32'hFFFFFFFE,  1'b1, 1'b0, 32'h0};
      vecs[11] = '{c_B1 + 32'h0,  4'h0, 32'h0,         1'b1, 1'b1, 32'h00000006};
      vecs[12] = '{c_B1 + 32'h0,  4'h1, 32'h0,         1'b1, 1'b0, 32'h0};
      vecs[13] = '{c_B1 + 32'h0,  4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[14] = '{c_B1 + 32'h8,  4'hF, 32'hA5A50001,  1'b1, 1'b0, 32'h0};
      vecs[15] = '{c_B1 + 32'h8,  4'h0, 32'h0,         1'b1, 1'b1, 32'hA5A50001};
      vecs[16] = '{32'h0200_0004, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0};
      vecs[17] = '{c_B1 + 32'h4,  4'h0, 32'h0,         1'b1, 1'b1, 32'h1234BEEF};
      vecs[18] = '{c_B1 + 32'hC,  4'hF, 32'h0,         1'b1, 1'b0, 32'h0};
      vecs[19] = '{c_B1 + 32'hC,  4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[20] = '{c_B4 + 32'h4,  4'hF, 32'h0000CAFE,  1'b1, 1'b0, 32'h0};
      vecs[21] = '{c_B4 + 32'h4,  4'h0, 32'h0,         1'b1, 1'b1, 32'h0000CAFE};
      vecs[22] = '{c_B1 + 32'h4,  4'h0, 32'h0,         1'b1, 1'b1, 32'h1234BEEF};

      reset = 1'b1;
      bus1.iomem_valid = 1'b0;
      bus1.iomem_wstrb = 4'b0000;
      bus1.iomem_addr  = 32'd0;
      bus1.iomem_wdata = 32'd0;
      repeat (3) step();
      chk("reset_ready", {31'd0, ready_any}, 32'd0);
      chk("reset_rdata", rdata_any, 32'd0);
      chk("reset_irq", {30'd0, irq4, irq1}, 32'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 23; i++) begin
         logic        rdy;
         logic [31:0] rd;
         access(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, rdy, rd);
         chk($sformatf("vec%0d_ready", i), {31'd0, rdy}, {31'd0, vecs[i].exp_rdy});
         if (vecs[i].chk_data) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
      end
      chk("table_irq", {30'd0, irq4, irq1}, 32'd0);

      // One-shot at PRESCALE=1: COUNT=3 expires on the 4th edge after the CTRL write.
      wr(c_B1 + 32'h8, 4'hF, 32'd3, "t3_count_wr");
      wr(c_B1 + 32'h0, 4'hF, 32'd5, "t3_ctrl_wr");
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("t3_irq_k%0d", k), {31'd0, irq1}, {31'd0, k >= 4});
         step();
      end
      rd_chk(c_B1 + 32'h0, 32'd4, "t3_ctrl_enable_cleared");
      rd_chk(c_B1 + 32'h8, 32'd0, "t3_count_held");
      rd_chk(c_B1 + 32'hC, 32'd1, "t3_status");

      // Auto-reload at PRESCALE=4, LOAD=1: expiries every 8 cycles.
      wr(c_B4 + 32'h4, 4'hF, 32'd1, "t4_load_wr");
      wr(c_B4 + 32'h8, 4'hF, 32'd1, "t4_count_wr");
      wr(c_B4 + 32'h0, 4'hF, 32'd7, "t4_ctrl_wr");
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("t4_irq_a_k%0d", k), {31'd0, irq4}, {31'd0, k >= 8});
         if (k < 8) step();
      end
      wr(c_B4 + 32'hC, 4'hF, 32'd1, "t4_w1c");
      for (int k = 10; k <= 16; k++) begin
         chk($sformatf("t4_irq_b_k%0d", k), {31'd0, irq4}, {31'd0, k >= 16});
         if (k < 16) step();
      end

      // W1C landing on the expiry edge loses to the set.
      wr(c_B1 + 32'hC, 4'hF, 32'd1, "t5_clear_wr");
      chk("t5_irq_cleared", {31'd0, irq1}, 32'd0);
      wr(c_B1 + 32'h8, 4'hF, 32'd2, "t5_count_wr");
      wr(c_B1 + 32'h0, 4'hF, 32'd5, "t5_ctrl_wr");
      step();
      wr(c_B1 + 32'hC, 4'hF, 32'd1, "t5_w1c_on_tick");
      rd_chk(c_B1 + 32'hC, 32'd1, "t5_status_kept");
      chk("t5_irq_kept", {31'd0, irq1}, 32'd1);
      wr(c_B1 + 32'hC, 4'hF, 32'd1, "t5_w1c");
      rd_chk(c_B1 + 32'hC, 32'd0, "t5_status_clr");

      // COUNT write on a tick edge wins; one further tick gives 0x54 at the read edge.
      wr(c_B1 + 32'h4, 4'hF, 32'h100, "t5_load_wr");
      wr(c_B1 + 32'h8, 4'hF, 32'd5, "t5_count5_wr");
      wr(c_B1 + 32'h0, 4'hF, 32'd3, "t5_run_wr");
      wr(c_B1 + 32'h8, 4'hF, 32'h55, "t5_count_override");
      rd_chk(c_B1 + 32'h8, 32'h54, "t5_count_after_override");
      wr(c_B1 + 32'h0, 4'hF, 32'd0, "t5_stop");

      // Reset during a write to the running, interrupting PRESCALE=4 instance.
      chk("t6_irq_before", {31'd0, irq4}, 32'd1);
      bus1.iomem_valid = 1'b1;
      bus1.iomem_addr  = c_B4 + 32'h4;
      bus1.iomem_wstrb = 4'hF;
      bus1.iomem_wdata = 32'h77;
      reset = 1'b1;
      step();
      chk("t6_ready", {31'd0, ready_any}, 32'd0);
      chk("t6_rdata", rdata_any, 32'd0);
      chk("t6_irq", {30'd0, irq4, irq1}, 32'd0);
      reset = 1'b0;
      bus1.iomem_valid = 1'b0;
      bus1.iomem_wstrb = 4'b0000;
      step();
      rd_chk(c_B4 + 32'h8, 32'd0, "t6_count");
      rd_chk(c_B4 + 32'h4, 32'd0, "t6_load_discarded");
      rd_chk(c_B4 + 32'h0, 32'd0, "t6_ctrl");
      rd_chk(c_B4 + 32'hC, 32'd0, "t6_status");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
